// File: rtl/naive_pipe_core.sv
// Four-stage in-order core (IF, ID, EX, WB) with full operand forwarding in ID,
// no hazard stalls, a HALT that freezes fetch, and a combinational observer port.
module naive_pipe_core #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RETW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     rom_data_i,
  input  logic            rom_ready_i,
  output logic [XLEN-1:0] rom_addr_o,
  output logic            rom_ce_o,
  input  logic [4:0]      ob_sel_i,
  input  logic [2:0]      ob_mode_i,
  output logic [XLEN-1:0] ob_data_o,
  output logic            halted_o
);

  localparam int SW = $clog2(XLEN);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_SLL  = 6'h06,
    OP_SRL  = 6'h07,
    OP_ADDI = 6'h08,
    OP_LUI  = 6'h09,
    OP_HALT = 6'h3F
  } op_e;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] regs [NREG];
  logic [RETW-1:0] retire_cnt;
  logic            halted;
  logic            err;

  logic            ifid_valid;
  logic [31:0]     ifid_instr;

  logic            idex_valid;
  logic            idex_we;
  op_e             idex_op;
  logic [4:0]      idex_rd;
  logic [XLEN-1:0] idex_a;
  logic [XLEN-1:0] idex_b;

  logic            exwb_valid;
  logic            exwb_we;
  logic [4:0]      exwb_rd;
  logic [XLEN-1:0] exwb_res;

  logic [5:0]      id_raw;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [15:0]     id_imm;
  logic            id_legal;
  op_e             id_op;
  logic            id_halt;
  logic            id_we;
  logic [XLEN-1:0] id_a;
  logic [XLEN-1:0] id_b;
  logic [XLEN-1:0] ex_res;
  logic            fetch;

  function automatic logic rd_ok(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) < NREG);
  endfunction

  // Youngest producer wins: EX result, then WB result, then the regfile.
  // A stage's write enable is only ever set for an in-range nonzero rd.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] r);
    if (idex_valid && idex_we && idex_rd == r) return ex_res;
    if (exwb_valid && exwb_we && exwb_rd == r) return exwb_res;
    if (rd_ok(r)) return regs[r[RW-1:0]];
    return '0;
  endfunction

  assign id_raw   = ifid_instr[31:26];
  assign id_rd    = ifid_instr[25:21];
  assign id_rs1   = ifid_instr[20:16];
  assign id_rs2   = ifid_instr[15:11];
  assign id_imm   = ifid_instr[15:0];
  assign id_legal = (id_raw <= 6'h09) || (id_raw == 6'h3F);
  assign id_op    = id_legal ? op_e'(id_raw) : OP_NOP;
  assign id_halt  = ifid_valid && (id_op == OP_HALT);
  assign id_we    = ifid_valid && (id_op != OP_NOP) && (id_op != OP_HALT) && rd_ok(id_rd);

  assign rom_addr_o = pc;
  assign rom_ce_o   = !halted && !rst;
  assign halted_o   = halted;
  assign fetch      = rom_ce_o && rom_ready_i && !id_halt;

  always_comb begin
    id_a = fwd(id_rs1);
    id_b = fwd(id_rs2);
    case (id_op)
      OP_ADDI: id_b = XLEN'($signed(id_imm));
      OP_LUI: begin
        id_a = '0;
        id_b = XLEN'(id_imm);
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_res = '0;
    case (idex_op)
      OP_ADD, OP_ADDI: ex_res = idex_a + idex_b;
      OP_SUB:          ex_res = idex_a - idex_b;
      OP_AND:          ex_res = idex_a & idex_b;
      OP_OR:           ex_res = idex_a | idex_b;
      OP_XOR:          ex_res = idex_a ^ idex_b;
      OP_SLL:          ex_res = idex_a << idex_b[SW-1:0];
      OP_SRL:          ex_res = idex_a >> idex_b[SW-1:0];
      OP_LUI:          ex_res = idex_b << (XLEN - 16);
      default:         ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      retire_cnt <= '0;
      halted     <= 1'b0;
      err        <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      idex_valid <= 1'b0;
      idex_we    <= 1'b0;
      idex_op    <= OP_NOP;
      idex_rd    <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      exwb_valid <= 1'b0;
      exwb_we    <= 1'b0;
      exwb_rd    <= '0;
      exwb_res   <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (exwb_valid && exwb_we) regs[exwb_rd[RW-1:0]] <= exwb_res;
      if (exwb_valid) retire_cnt <= retire_cnt + RETW'(1);

      exwb_valid <= idex_valid;
      exwb_we    <= idex_valid && idex_we;
      exwb_rd    <= idex_rd;
      exwb_res   <= ex_res;

      // HALT leaves ID as an invalid bubble so it neither writes nor retires.
      idex_valid <= ifid_valid && !id_halt;
      idex_we    <= id_we;
      idex_op    <= id_op;
      idex_rd    <= id_rd;
      idex_a     <= id_a;
      idex_b     <= id_b;

      if (id_halt) halted <= 1'b1;
      if (ifid_valid && !id_legal) err <= 1'b1;

      if (fetch) begin
        ifid_valid <= 1'b1;
        ifid_instr <= rom_data_i;
        pc         <= pc + XLEN'(4);
      end else begin
        ifid_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    ob_data_o = '0;
    case (ob_mode_i)
      3'd0: if (rd_ok(ob_sel_i)) ob_data_o = regs[ob_sel_i[RW-1:0]];
      3'd1: ob_data_o = pc;
      3'd2: ob_data_o = XLEN'(ifid_instr);
      3'd3: ob_data_o = idex_a;
      3'd4: ob_data_o = idex_b;
      3'd5: ob_data_o = ex_res;
      3'd6: ob_data_o = XLEN'(retire_cnt);
      default: ob_data_o = XLEN'({halted, err});
    endcase
  end

endmodule

// File: tb/tb_naive_pipe_core.sv
// Bench for naive_pipe_core: directed programs plus random programs checked
// against a sequential instruction-level model of the architectural state.
`timescale 1ns/1ps
module tb_naive_pipe_core;

  localparam int NREG = 8;

  logic        clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst = 1'b1;
  logic [31:0] rom_data;
  logic        rom_ready;
  logic [31:0] rom_addr;
  logic        rom_ce;
  logic [4:0]  ob_sel;
  logic [2:0]  ob_mode;
  logic [31:0] ob_data;
  logic        halted;

  logic [31:0] rom16_data;
  logic        rom16_ready;
  logic [15:0] rom16_addr;
  logic        rom16_ce;
  logic [15:0] ob16_data;
  logic        halted16;

  naive_pipe_core #(.XLEN(32), .NREG(NREG), .RETW(16)) u_dut (
    .clk(clk), .rst(rst), .rom_data_i(rom_data), .rom_ready_i(rom_ready),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .ob_sel_i(ob_sel), .ob_mode_i(ob_mode),
    .ob_data_o(ob_data), .halted_o(halted)
  );

  naive_pipe_core #(.XLEN(16), .NREG(32), .RETW(16)) u_dut16 (
    .clk(clk), .rst(rst), .rom_data_i(rom16_data), .rom_ready_i(rom16_ready),
    .rom_addr_o(rom16_addr), .rom_ce_o(rom16_ce), .ob_sel_i(ob_sel), .ob_mode_i(ob_mode),
    .ob_data_o(ob16_data), .halted_o(halted16)
  );

  logic [31:0] rom   [64];
  logic [31:0] rom16 [8];
  logic [31:0] prog  [$];
  int          ready_mode = 0;
  int unsigned cyc = 0;
  int unsigned ready_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] m_regs [32];
  int unsigned m_retire;
  logic [31:0] m_pc;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  // ROM model: presents the word at the current fetch address between edges.
  initial begin
    rom_ready = 1'b0; rom_data = '0; rom16_ready = 1'b0; rom16_data = '0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       rom_ready = 1'b1;
        1:       rom_ready = (cyc % 3 == 0);
        default: rom_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      if (rom_ready && !rst) ready_cnt++;
      rom_data    = ((rom_addr >> 2) < 64) ? rom[rom_addr[7:2]] : 32'h0;
      rom16_ready = 1'b1;
      rom16_data  = ((rom16_addr >> 2) < 8) ? rom16[rom16_addr[4:2]] : 32'h0;
    end
  end

  task automatic load_prog();
    for (int i = 0; i < 64; i++) rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    ready_cnt = 0;
  endtask

  task automatic peek(input logic [2:0] m, input logic [4:0] s, output logic [31:0] v);
    ob_mode = m; ob_sel = s;
    #1;
    v = ob_data;
  endtask

  task automatic peek16(input logic [2:0] m, input logic [4:0] s, output logic [31:0] v);
    ob_mode = m; ob_sel = s;
    #1;
    v = 32'(ob16_data);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    return (r == 0 || r >= NREG) ? 32'h0 : m_regs[r];
  endfunction

  // Executes prog one instruction at a time, as an ISA would describe it.
  task automatic model_run();
    logic [31:0] w, a, b, res;
    logic [15:0] imm;
    logic [5:0]  op;
    logic [4:0]  rd;
    bit          wr;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_retire = 0; m_pc = '0; m_err = 1'b0;
    foreach (prog[k]) begin
      w = prog[k]; op = w[31:26]; rd = w[25:21]; imm = w[15:0];
      m_pc = 32'((k + 1) * 4);
      if (op == 6'h3F) break;
      a = m_read(w[20:16]);
      b = m_read(w[15:11]);
      wr = 1'b1; res = '0;
      case (op)
        6'h00: wr = 1'b0;
        6'h01: res = a + b;
        6'h02: res = a - b;
        6'h03: res = a & b;
        6'h04: res = a | b;
        6'h05: res = a ^ b;
        6'h06: res = a << (b % 32);
        6'h07: res = a >> (b % 32);
        6'h08: res = a + {{16{imm[15]}}, imm};
        6'h09: res = {imm, 16'h0};
        default: begin wr = 1'b0; m_err = 1'b1; end
      endcase
      if (wr && rd != 0 && rd < NREG) m_regs[rd] = res;
      m_retire++;
    end
  endtask

  task automatic run_random(input int idx);
    int n, sel, k;
    logic [5:0] op;
    logic [31:0] v;
    prog.delete();
    n = $urandom_range(8, 30);
    repeat (n) begin
      sel = $urandom_range(0, 19);
      if (sel < 10)      op = 6'(sel);
      else if (sel < 19) op = 6'($urandom_range(1, 9));
      else               op = 6'($urandom_range(10, 62));
      if (op == 6'h08 || op == 6'h09)
        prog.push_back(i_ins(op, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                             16'($urandom)));
      else
        prog.push_back(r_ins(op, 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
                             5'($urandom_range(0, 11))));
    end
    prog.push_back(32'hFC00_0000);
    load_prog();
    model_run();
    ready_mode = 2;
    do_reset();
    k = 0;
    while (!halted && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("rnd%0d_halt_wait", idx), 32'(halted), 32'h1);
    repeat (6) @(posedge clk);
    #1;
    for (int r = 0; r < 12; r++) begin
      peek(3'd0, 5'(r), v);
      check($sformatf("rnd%0d_r%0d", idx, r), v, m_read(5'(r)));
    end
    peek(3'd6, 5'd0, v); check($sformatf("rnd%0d_retire", idx), v, m_retire);
    peek(3'd1, 5'd0, v); check($sformatf("rnd%0d_pc", idx), v, m_pc);
    peek(3'd7, 5'd0, v); check($sformatf("rnd%0d_flags", idx), v, {30'h0, 1'b1, m_err});
  endtask

  initial begin
    logic [31:0] v;
    ob_mode = '0; ob_sel = '0;

    // ADDI r1,5; ADDI r2,7; ADD r3,r1,r2 with ready held high.
    prog = '{i_ins(6'h08, 1, 0, 16'd5), i_ins(6'h08, 2, 0, 16'd7), r_ins(6'h01, 3, 1, 2)};
    load_prog();
    rom16[0] = i_ins(6'h08, 1, 0, 16'hFFFF);
    rom16[1] = i_ins(6'h08, 1, 1, 16'd2);
    rom16[2] = i_ins(6'h09, 2, 0, 16'h1234);
    for (int i = 3; i < 8; i++) rom16[i] = '0;
    ready_mode = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ce_during_rst", 32'(rom_ce), 32'h0);
    for (int m = 0; m < 8; m++) begin
      peek(3'(m), 5'd1, v);
      check($sformatf("rst_mode%0d", m), v, 32'h0);
    end
    rst = 1'b0; cyc = 0; ready_cnt = 0;
    #1;
    check("ce_after_rst", 32'(rom_ce), 32'h1);
    check("addr_after_rst", rom_addr, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    peek(3'd0, 5'd3, v); check("r3_at_E4", v, 32'h0);
    @(posedge clk);
    #1;
    peek(3'd0, 5'd3, v); check("r3_at_E5", v, 32'd12);
    peek(3'd6, 5'd0, v); check("retire_at_E5", v, 32'd3);
    peek(3'd0, 5'd1, v); check("r1_fwd", v, 32'd5);
    peek(3'd0, 5'd2, v); check("r2_fwd", v, 32'd7);
    peek16(3'd0, 5'd1, v); check("x16_addi_wrap", v, 32'h0001);
    peek16(3'd0, 5'd2, v); check("x16_lui", v, 32'h1234);

    // Reset with the pipeline full: nothing in flight may survive.
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    peek(3'd0, 5'd1, v); check("pre_rst_r1", v, 32'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ce_mid_rst", 32'(rom_ce), 32'h0);
    for (int m = 0; m < 8; m++) begin
      peek(3'(m), 5'd2, v);
      check($sformatf("midrst_mode%0d", m), v, 32'h0);
    end
    peek(3'd0, 5'd1, v); check("midrst_r1", v, 32'h0);
    rst = 1'b0;

    // Same program, ready pattern 1,0,0,...
    ready_mode = 1;
    do_reset();
    repeat (20) @(posedge clk);
    #1;
    peek(3'd0, 5'd1, v); check("slow_r1", v, 32'd5);
    peek(3'd0, 5'd2, v); check("slow_r2", v, 32'd7);
    peek(3'd0, 5'd3, v); check("slow_r3", v, 32'd12);
    peek(3'd1, 5'd0, v); check("slow_pc", v, 32'(ready_cnt * 4));
    for (int r = 4; r < 8; r++) begin
      peek(3'd0, 5'(r), v);
      check($sformatf("slow_r%0d_clean", r), v, 32'h0);
    end

    // HALT stops fetch; the instruction behind it never executes.
    prog = '{i_ins(6'h08, 1, 0, 16'd1), 32'hFC00_0000, i_ins(6'h08, 2, 0, 16'd9)};
    load_prog();
    ready_mode = 0;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    peek(3'd0, 5'd1, v); check("halt_r1", v, 32'd1);
    peek(3'd0, 5'd2, v); check("halt_r2", v, 32'd0);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_ce", 32'(rom_ce), 32'h0);
    peek(3'd1, 5'd0, v); check("halt_pc", v, 32'd8);
    peek(3'd6, 5'd0, v); check("halt_retire", v, 32'd1);
    peek(3'd7, 5'd0, v); check("halt_flags", v, 32'h2);

    // Illegal opcode sets err; writes to r0 are dropped.
    prog = '{i_ins(6'h15, 1, 0, 16'd0), i_ins(6'h08, 0, 0, 16'd3)};
    load_prog();
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    peek(3'd7, 5'd0, v); check("illegal_flags", v, 32'h1);
    peek(3'd0, 5'd0, v); check("r0_zero", v, 32'h0);
    peek(3'd0, 5'd1, v); check("illegal_no_write", v, 32'h0);

    for (int t = 0; t < 10; t++) run_random(t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
